// File: rtl/icache_axi_fill_unit_if.sv
// AXI3 read-only channel between the instruction cache refill engine and memory.
interface icache_axi_fill_unit_if #(
  parameter int unsigned DATA_LENGTH = 32
);
  logic [31:0]            ARADDR;
  logic                   ARVALID;
  logic                   ARREADY;
  logic [3:0]             ARLEN;
  logic [1:0]             ARBURST;
  logic [DATA_LENGTH-1:0] RDATA;
  logic                   RVALID;
  logic                   RREADY;

  // Cache side issues bursts and accepts read data.
  modport master (
    output ARADDR, ARVALID, ARLEN, ARBURST, RREADY,
    input  ARREADY, RDATA, RVALID
  );

  // Memory side accepts bursts and returns read data.
  modport slave (
    input  ARADDR, ARVALID, ARLEN, ARBURST, RREADY,
    output ARREADY, RDATA, RVALID
  );
endinterface

// File: rtl/icache_axi_fill_unit.sv
// Set-associative read-only instruction cache with a single-burst AXI3 line refill engine.
// Hits are answered combinationally in IDLE; a miss fetches the whole line into the victim way.
module icache_axi_fill_unit #(
  parameter int unsigned DATA_LENGTH = 32,
  parameter int unsigned CACHE_SIZE  = 32768,
  parameter int unsigned LINE_SIZE   = 64,
  parameter int unsigned WAYS        = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [31:0]            addr,
  input  logic                   fetch_req,
  output logic [DATA_LENGTH-1:0] data_out,
  output logic                   hit,
  output logic                   miss_detected,
  icache_axi_fill_unit_if.master axi
);

  localparam int unsigned BYTES_PER_BEAT = DATA_LENGTH / 8;
  localparam int unsigned BEATS          = LINE_SIZE / BYTES_PER_BEAT;
  localparam int unsigned SETS           = CACHE_SIZE / (LINE_SIZE * WAYS);
  localparam int unsigned BYTE_W         = $clog2(BYTES_PER_BEAT);
  localparam int unsigned WSEL_W         = $clog2(BEATS);
  localparam int unsigned OFF_W          = $clog2(LINE_SIZE);
  localparam int unsigned IDX_W          = $clog2(SETS);
  localparam int unsigned TAG_W          = 32 - IDX_W - OFF_W;
  localparam int unsigned WAY_W          = $clog2(WAYS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_t;

  // Line storage: data and tags read asynchronously, valid bits and pointers reset.
  logic [DATA_LENGTH-1:0]       data_q [SETS][WAYS][BEATS];
  logic [TAG_W-1:0]             tag_q  [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0]    valid_q;
  logic [SETS-1:0][WAY_W-1:0]   rr_q;

  state_t                       state_q;
  logic                         arvalid_q;
  logic                         rready_q;
  logic                         miss_q;
  logic                         flush_pend_q;
  logic [31:0]                  araddr_q;
  logic [WSEL_W-1:0]            beat_q;
  logic [WAY_W-1:0]             victim_q;

  logic [WSEL_W-1:0]            word_sel;
  logic [IDX_W-1:0]             idx;
  logic [TAG_W-1:0]             tag;
  logic [IDX_W-1:0]             fill_idx;
  logic [TAG_W-1:0]             fill_tag;
  logic                         tag_hit;
  logic [WAY_W-1:0]             hit_way;
  logic                         inv_found;
  logic [WAY_W-1:0]             victim_c;
  logic                         beat_fire;
  logic                         last_beat;
  logic                         unused_addr_bits;

  assign word_sel         = addr[BYTE_W +: WSEL_W];
  assign idx              = addr[OFF_W +: IDX_W];
  assign tag              = addr[OFF_W + IDX_W +: TAG_W];
  assign unused_addr_bits = ^addr[BYTE_W-1:0];

  // The line being refilled is identified by the latched burst address.
  assign fill_idx  = araddr_q[OFF_W +: IDX_W];
  assign fill_tag  = araddr_q[OFF_W + IDX_W +: TAG_W];

  assign beat_fire = (state_q == FILL) && rready_q && axi.RVALID;
  assign last_beat = (beat_q == WSEL_W'(BEATS - 1));

  // Tag compare across the indexed set; first matching valid way wins.
  always_comb begin
    tag_hit = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!tag_hit && valid_q[idx][WAY_W'(w)] && (tag_q[idx][WAY_W'(w)] == tag)) begin
        tag_hit = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim choice: lowest invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    inv_found = 1'b0;
    victim_c  = rr_q[idx];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!inv_found && !valid_q[idx][WAY_W'(w)]) begin
        inv_found = 1'b1;
        victim_c  = WAY_W'(w);
      end
    end
  end

  assign hit      = fetch_req && (state_q == IDLE) && tag_hit;
  assign data_out = hit ? data_q[idx][hit_way][word_sel] : '0;

  assign axi.ARADDR  = araddr_q;
  assign axi.ARVALID = arvalid_q;
  assign axi.RREADY  = rready_q;
  assign axi.ARLEN   = 4'(BEATS - 1);
  assign axi.ARBURST = 2'b01;
  assign miss_detected = miss_q;

  // Refill write port: each accepted beat lands in the victim way; the tag goes in with the last beat.
  always_ff @(posedge clk) begin
    if (!rst && beat_fire) begin
      data_q[fill_idx][victim_q][beat_q] <= axi.RDATA;
      if (last_beat) begin
        tag_q[fill_idx][victim_q] <= fill_tag;
      end
    end
  end

  // Miss/refill controller plus valid-bit and replacement-pointer maintenance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      miss_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      araddr_q     <= '0;
      beat_q       <= '0;
      victim_q     <= '0;
      valid_q      <= '0;
      rr_q         <= '0;
    end else begin
      if (flush) begin
        valid_q <= '0;
        rr_q    <= '0;
      end
      case (state_q)
        IDLE: begin
          if (fetch_req && !tag_hit) begin
            victim_q     <= victim_c;
            araddr_q     <= {tag, idx, {OFF_W{1'b0}}};
            arvalid_q    <= 1'b1;
            miss_q       <= 1'b1;
            flush_pend_q <= 1'b0;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (flush) begin
            flush_pend_q <= 1'b1;
          end
          if (axi.ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= '0;
            state_q   <= FILL;
          end
        end
        FILL: begin
          if (flush) begin
            flush_pend_q <= 1'b1;
          end
          if (beat_fire) begin
            beat_q <= beat_q + WSEL_W'(1);
            if (last_beat) begin
              // A flush seen at any point during the burst leaves the new line invalid.
              if (!flush && !flush_pend_q) begin
                valid_q[fill_idx][victim_q] <= 1'b1;
                rr_q[fill_idx]              <= rr_q[fill_idx] + WAY_W'(1);
              end
              rready_q <= 1'b0;
              miss_q   <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_axi_fill_unit.sv
// Scoreboard bench: a line-presence model predicts hits/misses and burst addresses,
// a memory function supplies line contents, and a monitor compares what the cache presents.
module tb_icache_axi_fill_unit;

  localparam int unsigned DL     = 32;
  localparam int          M_SETS = 64;
  localparam int          M_WAYS = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [31:0]   addr = 32'h0;
  logic          fetch_req = 1'b0;
  logic [DL-1:0] data_out;
  logic          hit;
  logic          miss_detected;

  icache_axi_fill_unit_if #(.DATA_LENGTH(DL)) axi ();

  icache_axi_fill_unit #(
    .DATA_LENGTH(DL),
    .CACHE_SIZE (32768),
    .LINE_SIZE  (64),
    .WAYS       (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .addr         (addr),
    .fetch_req    (fetch_req),
    .data_out     (data_out),
    .hit          (hit),
    .miss_detected(miss_detected),
    .axi          (axi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing memory: the 0x1000 line holds 0..15, everything else a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:6] == 26'h40) return {28'h0, a[5:2]};
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Cache contents model: which line tag sits in which way, plus the per-set rotation pointer.
  bit          m_valid [M_SETS][M_WAYS];
  logic [19:0] m_tag   [M_SETS][M_WAYS];
  int          m_rr    [M_SETS];

  function automatic bit model_present(input logic [31:0] a);
    int s = int'(a[11:6]);
    for (int w = 0; w < M_WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == a[31:12]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_victim(input logic [31:0] a);
    int s = int'(a[11:6]);
    for (int w = 0; w < M_WAYS; w++)
      if (!m_valid[s][w]) return w;
    return m_rr[s];
  endfunction

  task automatic model_install(input logic [31:0] a, input int way);
    int s = int'(a[11:6]);
    m_valid[s][way] = 1'b1;
    m_tag[s][way]   = a[31:12];
    m_rr[s]         = (m_rr[s] + 1) % M_WAYS;
  endtask

  task automatic model_flush();
    for (int s = 0; s < M_SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < M_WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  typedef struct {
    bit          exp_hit;
    logic [31:0] exp_data;
    logic [31:0] a;
  } fexp_t;

  fexp_t       fetch_q[$];
  logic [31:0] ar_q[$];

  int ar_delay_cfg = -1;
  int gap_cfg      = -1;

  // Monitor: compare every presented fetch and every accepted burst against the queued expectation.
  always @(negedge clk) begin
    fexp_t       e;
    logic [31:0] ea;
    if (!rst) begin
      if (fetch_req && !miss_detected) begin
        if (fetch_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL fetch_unexpected: addr 0x%0h hit %0b with no expectation", addr, hit);
        end else begin
          e = fetch_q.pop_front();
          check($sformatf("fetch_hit@%0h", e.a), 64'(hit), 64'(e.exp_hit));
          check($sformatf("fetch_data@%0h", e.a), 64'(data_out), 64'(e.exp_data));
        end
      end
      if (fetch_req && miss_detected) begin
        check("busy_hit", 64'(hit), 64'h0);
        check("busy_data", 64'(data_out), 64'h0);
      end
      if (axi.ARVALID && axi.ARREADY) begin
        if (ar_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ar_unexpected: ARADDR 0x%0h with no burst expected", axi.ARADDR);
        end else begin
          ea = ar_q.pop_front();
          check("ar_addr", 64'(axi.ARADDR), 64'(ea));
          check("ar_len", 64'(axi.ARLEN), 64'd15);
          check("ar_burst", 64'(axi.ARBURST), 64'd1);
        end
      end
    end
  end

  // AXI memory responder with configurable or random address backpressure and beat gaps.
  initial begin : responder
    logic [31:0] a;
    int          d;
    int          g;
    forever begin
      @(posedge clk); #1;
      if (!rst && axi.ARVALID) begin
        a = axi.ARADDR;
        d = (ar_delay_cfg < 0) ? int'($urandom_range(0, 3)) : ar_delay_cfg;
        repeat (d) begin
          @(posedge clk); #1;
          check("ar_hold_valid", 64'(axi.ARVALID), 64'h1);
          check("ar_hold_addr", 64'(axi.ARADDR), 64'(a));
        end
        axi.ARREADY = 1'b1;
        @(posedge clk); #1;
        axi.ARREADY = 1'b0;
        check("ar_drop_valid", 64'(axi.ARVALID), 64'h0);
        check("r_ready_up", 64'(axi.RREADY), 64'h1);
        for (int b = 0; b < 16; b++) begin
          g = (gap_cfg < 0) ? int'($urandom_range(0, 2)) : gap_cfg;
          repeat (g) begin
            @(posedge clk); #1;
          end
          axi.RVALID = 1'b1;
          axi.RDATA  = mem_word(a + 32'(4 * b));
          @(posedge clk); #1;
          axi.RVALID = 1'b0;
        end
        check("miss_cleared", 64'(miss_detected), 64'h0);
        check("r_ready_down", 64'(axi.RREADY), 64'h0);
      end
    end
  end

  // One CPU fetch: present, and on a miss wait out the refill and re-present until it hits.
  task automatic do_fetch(input logic [31:0] a, input int ard, input int gap,
                          input bit flush_mid, input logic [31:0] probe);
    bit          present;
    int          way;
    bit          dropped;
    int          waitc;
    logic [31:0] line;
    line = {a[31:6], 6'b0};
    for (int attempt = 0; attempt < 4; attempt++) begin
      present      = model_present(a);
      way          = 0;
      ar_delay_cfg = ard;
      gap_cfg      = gap;
      @(posedge clk); #1;
      addr      = a;
      fetch_req = 1'b1;
      fetch_q.push_back('{present, present ? mem_word(a) : 32'h0, a});
      if (!present) begin
        way = model_victim(a);
        ar_q.push_back(line);
      end
      @(posedge clk); #1;
      if (present) begin
        fetch_req = 1'b0;
        return;
      end
      check("launch_miss", 64'(miss_detected), 64'h1);
      check("launch_arvalid", 64'(axi.ARVALID), 64'h1);
      check("launch_araddr", 64'(axi.ARADDR), 64'(line));
      check("launch_arlen", 64'(axi.ARLEN), 64'd15);
      // Fetches while busy must be ignored.
      addr = probe;
      repeat (2) begin
        @(posedge clk); #1;
      end
      fetch_req = 1'b0;
      addr      = a;
      dropped   = 1'b0;
      if (flush_mid && attempt == 0) begin
        repeat ($urandom_range(1, 6)) begin
          @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_flush();
        dropped = 1'b1;
      end
      waitc = 0;
      while (miss_detected && waitc < 400) begin
        @(posedge clk); #1;
        waitc++;
      end
      if (miss_detected) begin
        n_checks++;
        n_fail++;
        $display("FAIL refill_timeout: miss_detected still 1 for line 0x%0h", line);
        return;
      end
      if (!dropped) model_install(a, way);
    end
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_flush();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] ra;
    axi.ARREADY = 1'b0;
    axi.RVALID  = 1'b0;
    axi.RDATA   = '0;
    model_flush();

    // Reset with a fetch pending: nothing may hit and the AXI side stays quiet.
    rst       = 1'b1;
    addr      = 32'h0000_1000;
    fetch_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hit", 64'(hit), 64'h0);
    check("rst_miss", 64'(miss_detected), 64'h0);
    check("rst_arvalid", 64'(axi.ARVALID), 64'h0);
    check("rst_rready", 64'(axi.RREADY), 64'h0);
    check("rst_araddr", 64'(axi.ARADDR), 64'h0);
    fetch_req = 1'b0;
    rst       = 1'b0;

    // Cold miss, then word hits within the filled line.
    do_fetch(32'h0000_1000, 0, 0, 1'b0, 32'h0000_1000);
    do_fetch(32'h0000_1000, 0, 0, 1'b0, 32'h0);
    do_fetch(32'h0000_1008, 0, 0, 1'b0, 32'h0);
    do_fetch(32'h0000_103C, 0, 0, 1'b0, 32'h0);

    // Address backpressure and gapped beats.
    do_fetch(32'h0000_2004, 5, 1, 1'b0, 32'h0000_1008);

    // Fill the rest of set 0, then force a round-robin eviction.
    for (int t = 3; t <= 8; t++)
      do_fetch(32'(t) << 12, -1, -1, 1'b0, 32'h0000_1004);
    do_fetch(32'h0000_9000, -1, -1, 1'b0, 32'h0000_2000);
    do_fetch(32'h0000_2000, -1, -1, 1'b0, 32'h0);
    do_fetch(32'h0000_1000, -1, -1, 1'b0, 32'h0000_2000);

    // Flush while idle, then flush in the middle of a burst.
    do_flush();
    do_fetch(32'h0000_2000, -1, -1, 1'b0, 32'h0000_2000);
    do_fetch(32'h0000_5000, -1, -1, 1'b1, 32'h0000_2000);

    // Random traffic over a few sets and more tags than ways.
    for (int i = 0; i < 60; i++) begin
      ra = {12'h0, 8'($urandom_range(1, 10)), 6'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 19) == 0) do_flush();
      do_fetch(ra, -1, -1, ($urandom_range(0, 14) == 0), 32'h0000_1000);
    end

    repeat (5) @(posedge clk);
    #1;
    check("fetch_q_drained", 64'(fetch_q.size()), 64'h0);
    check("ar_q_drained", 64'(ar_q.size()), 64'h0);
    check("idle_miss", 64'(miss_detected), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
